// File: rtl/btn_sw_cmd.sv
// Switch/button front end: synchronise, debounce the north button and emit one
// registered switch-snapshot command per clean press over a valid/ready handshake.
module btn_sw_cmd #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET_N,
  input  logic [3:0] SW,
  input  logic       BTN_NORTH,
  output logic       CMD_VALID,
  output logic [3:0] CMD_DATA,
  input  logic       CMD_READY,
  output logic       BTN_LEVEL,
  output logic [7:0] DROP_CNT
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdleLow,
    StWaitHigh,
    StPressed,
    StWaitLow
  } state_e;

  // Bit 4 carries the button, bits 3:0 the switches.
  logic [4:0] sync1_q, sync2_q;
  logic [3:0] sw_s;
  logic       btn_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt;

  logic       valid_q, valid_d;
  logic [3:0] data_q, data_d;
  logic [7:0] drop_q, drop_d;

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {BTN_NORTH, SW};
      sync2_q <= sync1_q;
    end
  end

  assign sw_s  = sync2_q[3:0];
  assign btn_s = sync2_q[4];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    unique case (state_q)
      StIdleLow: begin
        if (btn_s) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!btn_s) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = StPressed;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!btn_s) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        // A release never generates an event; a re-press just restores the level.
        if (btn_s) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleLow;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdleLow;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    if (press_evt) begin
      if (!valid_q || CMD_READY) begin
        valid_d = 1'b1;
        data_d  = sw_s;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (valid_q && CMD_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign CMD_VALID = valid_q;
  assign CMD_DATA  = data_q;
  assign DROP_CNT  = drop_q;
  assign BTN_LEVEL = (state_q == StPressed) || (state_q == StWaitLow);

endmodule

// File: tb/tb_btn_sw_cmd.sv
// Directed bench for btn_sw_cmd with a 4-cycle debounce: a per-cycle vector table for
// the clean press/accept/release, then hand-written bounce, drop, coincident-accept and reset cases.
module tb_btn_sw_cmd;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic       cmd_valid;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic       btn_level;
  logic [7:0] drop_cnt;

  int passed = 0;
  int total  = 0;

  btn_sw_cmd #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLK_50MHZ(clk),
    .RESET_N  (rst_n),
    .SW       (sw),
    .BTN_NORTH(btn),
    .CMD_VALID(cmd_valid),
    .CMD_DATA (cmd_data),
    .CMD_READY(cmd_ready),
    .BTN_LEVEL(btn_level),
    .DROP_CNT (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic [3:0] sw;
    logic       rdy;
    logic       exp_valid;
    logic [3:0] exp_data;
    logic       exp_level;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic v, input logic [3:0] d,
                           input logic l, input logic [7:0] c);
    check({tag, ".valid"}, {31'd0, cmd_valid}, {31'd0, v});
    check({tag, ".data"}, {28'd0, cmd_data}, {28'd0, d});
    check({tag, ".level"}, {31'd0, btn_level}, {31'd0, l});
    check({tag, ".drop"}, {24'd0, drop_cnt}, {24'd0, c});
  endtask

  // Hold the button long enough to debounce, then release long enough to settle.
  task automatic press();
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Clean press from idle: edge 7 raises valid/level, idx 16 accepts, idx 17 starts release.
    for (int i = 0; i < 25; i++) begin
      vecs[i].btn       = (i < 17);
      vecs[i].sw        = 4'b0101;
      vecs[i].rdy       = (i == 16);
      vecs[i].exp_valid = (i >= 6 && i <= 15);
      vecs[i].exp_data  = (i >= 6) ? 4'b0101 : 4'b0000;
      vecs[i].exp_level = (i >= 6 && i <= 22);
      vecs[i].exp_drop  = 8'd0;
    end

    // 1. Reset values
    rst_n     = 1'b0;
    sw        = 4'b1111;
    btn       = 1'b0;
    cmd_ready = 1'b0;
    tick(3);
    check_all("reset", 1'b0, 4'h0, 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sw        = 4'(i);
      cmd_ready = i[0];
      tick(1);
      check("idle_valid", {31'd0, cmd_valid}, 32'd0);
    end
    cmd_ready = 1'b0;
    sw        = 4'b0101;
    tick(2);

    // 2. Clean press via vector table
    for (int i = 0; i < 25; i++) begin
      btn       = vecs[i].btn;
      sw        = vecs[i].sw;
      cmd_ready = vecs[i].rdy;
      tick(1);
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                vecs[i].exp_level, vecs[i].exp_drop);
    end
    cmd_ready = 1'b0;

    // 3. Bounce: 1,1,0,1,0 then stable high
    sw = 4'b1010;
    tick(3);
    btn = 1'b1; tick(1); check("bounce_lvl", {31'd0, btn_level}, 32'd0);
    tick(1);    check("bounce_lvl", {31'd0, btn_level}, 32'd0);
    btn = 1'b0; tick(1); check("bounce_lvl", {31'd0, btn_level}, 32'd0);
    btn = 1'b1; tick(1); check("bounce_lvl", {31'd0, btn_level}, 32'd0);
    btn = 1'b0; tick(1); check("bounce_lvl", {31'd0, btn_level}, 32'd0);
    btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("bounce_pre_valid", {31'd0, cmd_valid}, 32'd0);
      check("bounce_pre_lvl", {31'd0, btn_level}, 32'd0);
    end
    tick(1);
    check_all("bounce_cmd", 1'b1, 4'b1010, 1'b1, 8'd0);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("bounce_accept", {31'd0, cmd_valid}, 32'd0);
    tick(10);
    check("bounce_single", {31'd0, cmd_valid}, 32'd0);
    btn = 1'b0;
    tick(10);
    check_all("bounce_released", 1'b0, 4'b1010, 1'b0, 8'd0);

    // 4. Drops while a command is pending
    sw = 4'b0101;
    press();
    check_all("drop_first", 1'b1, 4'b0101, 1'b0, 8'd0);
    sw = 4'b0100;
    press();
    check_all("drop_one", 1'b1, 4'b0101, 1'b0, 8'd1);
    for (int i = 0; i < 258; i++) press();
    check_all("drop_sat", 1'b1, 4'b0101, 1'b0, 8'd255);

    // 5. Accept on the same edge as a new press
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_all("reset2", 1'b0, 4'h0, 1'b0, 8'd0);
    sw = 4'b0101;
    press();
    check_all("coin_pending", 1'b1, 4'b0101, 1'b0, 8'd0);
    sw  = 4'b0100;
    btn = 1'b1;
    tick(6);
    check_all("coin_pre", 1'b1, 4'b0101, 1'b0, 8'd0);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check_all("coin_evt", 1'b1, 4'b0100, 1'b1, 8'd0);
    tick(1);
    check("coin_hold", {31'd0, cmd_valid}, 32'd1);

    // 6. Asynchronous reset while in WAIT_HIGH with a command pending
    btn = 1'b0;
    tick(8);
    btn = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 4'h0, 1'b0, 8'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tick(5);
    check("post_rst_pre", {31'd0, cmd_valid}, 32'd0);
    tick(1);
    check_all("post_rst_cmd", 1'b1, 4'b0100, 1'b1, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/btn_sw_cmd.md
# btn_sw_cmd

Input front end for the candle display board. Synchronises the four slide switches and the north push-button to `CLK_50MHZ`, debounces the button, and turns each clean press into one command word, a snapshot of the switches. The word goes to the downstream candle logic through a valid/ready handshake. It is the input-side counterpart of the LED output path: switches and button in, registered commands out.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000, is the number of consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz). Must be at least 2.
- `CNT_W`, default 20, is the debounce counter width. Must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`.

Ports:
- `CLK_50MHZ`  in  1  system clock; all flops rise-edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `SW`  in  4  raw switches {SW3,SW2,SW1,SW0}; asynchronous to the clock.
- `BTN_NORTH`  in  1  raw button, active-high, bouncy, asynchronous.
- `CMD_VALID`  out  1  a command is pending.
- `CMD_DATA`  out  4  switch snapshot taken at the press.
- `CMD_READY`  in  1  consumer accepts the command.
- `BTN_LEVEL`  out  1  debounced button level.
- `DROP_CNT`  out  8  count of presses lost because a command was still pending; saturates.

## Operation
- **Synchronisers.** Two-flop synchronisers on `SW[3:0]` and `BTN_NORTH` produce `sw_s` and `btn_s`. Both reset to 0.
- **Debounce FSM.** Four states: `IDLE_LOW`, `WAIT_HIGH`, `PRESSED`, `WAIT_LOW`. It uses counter `cnt` of width `CNT_W`.
  - `IDLE_LOW`: if `btn_s`=1, go to `WAIT_HIGH` and set `cnt`=0.
  - `WAIT_HIGH`:
    - If `btn_s`=0, return to `IDLE_LOW` and set `cnt`=0.
    - Else if `cnt`=`DEBOUNCE_CYCLES`-1, go to `PRESSED` and raise `press_evt` for this edge.
    - Else increment `cnt`.
  - `PRESSED`: if `btn_s`=0, go to `WAIT_LOW` and set `cnt`=0.
  - `WAIT_LOW`:
    - If `btn_s`=1, return to `PRESSED`.
    - Else if `cnt`=`DEBOUNCE_CYCLES`-1, go to `IDLE_LOW`.
    - Else increment `cnt`.
    - A release produces no event.
- `BTN_LEVEL` is 1 in `PRESSED` and `WAIT_LOW`, and 0 otherwise. It is decoded from the registered state.
- **Command register.** On the edge where `press_evt` fires:
  - If `CMD_VALID`=0, or `CMD_READY`=1 (an accept on the same edge): load `CMD_DATA`←`sw_s` and set `CMD_VALID`=1.
  - Otherwise the press is dropped. `CMD_DATA` is unchanged and `DROP_CNT` increments, saturating at 255.
- **Accept.** An edge with `CMD_VALID`=1, `CMD_READY`=1 and no `press_evt` clears `CMD_VALID`. `CMD_DATA` holds its last value.
- `CMD_READY` is ignored while `CMD_VALID`=0.
- **Button held through reset release.** Treated as a new press, because the synchroniser starts at 0. It yields one command after the normal latency.
- **Switch changes** alone never produce a command.

## Timing
- Reset (asynchronous, immediate on `RESET_N`=0):
  - `CMD_VALID`=0, `CMD_DATA`=0000, `BTN_LEVEL`=0, `DROP_CNT`=0.
  - FSM in `IDLE_LOW`, `cnt`=0, all synchroniser flops 0.
  - A pending command or a partial debounce is discarded.
- **Press latency.** Call edge 1 the first edge that samples `BTN_NORTH`=1, with the button held stable from then on.
  - `btn_s` rises after edge 2.
  - The FSM enters `WAIT_HIGH` at edge 3.
  - `CMD_VALID` and `BTN_LEVEL` rise after edge `DEBOUNCE_CYCLES`+3.
  - `CMD_DATA` equals `SW` as sampled at edge `DEBOUNCE_CYCLES`+1.
- **Release latency.** `BTN_LEVEL` falls after edge `DEBOUNCE_CYCLES`+3, counted from the first edge sampling `BTN_NORTH`=0.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count. Latency is measured from the last stable transition.
- Handshake:
  - `CMD_VALID` stays asserted until accepted and deasserts the cycle after the accepting edge.
  - Maximum throughput is one command per press. Presses are at least 2×`DEBOUNCE_CYCLES`+2 cycles apart.
- All outputs are registered. There is no combinational path from `CMD_READY` to any output.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `CNT_W`=3.
1. **Reset values.** Hold `RESET_N`=0 with `SW`=1111 and `BTN_NORTH`=0 → all outputs 0. Release reset and run 20 cycles → `CMD_VALID` stays 0.
2. **Clean press.**
   - Drive `SW`=0101, then `BTN_NORTH`=1 held → `CMD_VALID`=1 and `BTN_LEVEL`=1 after edge 7, `CMD_DATA`=0101.
   - `CMD_VALID` holds for 10 cycles with `CMD_READY`=0.
   - Pulse `CMD_READY` for 1 cycle → `CMD_VALID`=0 on the next cycle.
3. **Bounce.** Button high 2 cycles, low 1, high 1, low 1, then high stable → exactly one command. `CMD_VALID` rises 7 edges after the final rise. `BTN_LEVEL` stays 0 throughout the bounce.
4. **Drop.**
   - Press with `SW`=0101, leave it unaccepted, release.
   - Set `SW`=0100 and press again → `DROP_CNT`=1, `CMD_DATA`=0101, `CMD_VALID`=1.
   - Repeat for 260 presses → `DROP_CNT`=255.
5. **Accept coincident with new press.** Assert `CMD_READY` on exactly the `press_evt` edge of a second press with `SW`=0100 → `CMD_VALID` stays 1, `CMD_DATA`=0100, `DROP_CNT` unchanged.
6. **Reset mid-operation.**
   - Pulse `RESET_N` low mid-cycle while in `WAIT_HIGH`, with a command pending → outputs clear before the next edge.
   - Button still held after release → a new command appears 7 edges later.
